my_mem_responder: RTL and testbench
===================================

MY_MEM_RESPONDER -- requirements
Module: my_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width; memory depth DEPTH = 2**ADDR_W words of 9 bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port write  input  1  write request, sampled on posedge clk.
REQ-005 SHALL have port read  input  1  read request, sampled on posedge clk.
REQ-006 SHALL have port data_in  input  8  write data.
REQ-007 SHALL have port address  input  ADDR_W  word address for read or write.
REQ-008 SHALL have port inj_par  input  1  test-only; when high with an accepted write, the stored parity bit is inverted.
REQ-009 SHALL have port data_out  output  9  read data {parity, data[7:0]}.
REQ-010 SHALL have port data_valid  output  1  one-cycle strobe marking data_out as new read data.
REQ-011 SHALL have port ready  output  1  high when requests are accepted.
REQ-012 SHALL have port collision_count  output  16  saturating count of cycles with write and read both high.
REQ-013 SHALL have port parity_error  output  1  parity check result, qualified by data_valid.

Function
REQ-014 SHALL implement two states, INIT and IDLE; reset forces INIT with init pointer = 0.
REQ-015 In INIT, SHALL write 9'h000 to mem[init pointer] each cycle, increment the pointer, and move to IDLE after writing DEPTH-1 (exactly DEPTH cycles in INIT).
REQ-016 ready SHALL be 0 in INIT and 1 in IDLE (registered; ready rises on the same edge as the INIT->IDLE transition).
REQ-017 In INIT, write, read and inj_par SHALL be ignored: no store, no data_valid, no collision count.
REQ-018 In IDLE, write=1 and read=0 SHALL store mem[address] <= {(^data_in) ^ inj_par, data_in} at that edge (even parity: 9-bit word has an even number of ones when inj_par=0).
REQ-019 In IDLE, read=1 and write=0 SHALL load data_out <= mem[address] and assert data_valid for exactly one cycle at the next edge (1-cycle latency).
REQ-020 parity_error SHALL be registered with data_out as data_out[8] != ^data_out[7:0] for the read word; it SHALL be 0 whenever data_valid is 0.
REQ-021 When data_valid is 0, data_out SHALL hold its last value.
REQ-022 In IDLE, write=1 and read=1 SHALL perform neither access, SHALL keep data_valid 0, and SHALL increment collision_count by 1, saturating at 16'hFFFF.
REQ-023 A read on the cycle after a write to the same address SHALL return the newly written word.
REQ-024 Back-to-back reads SHALL be accepted every cycle, each producing data_valid one cycle later.
REQ-025 Address wrap: address is used modulo DEPTH; no out-of-range condition exists.

Reset
REQ-026 Asserting reset at any time, including mid-INIT or mid-read, SHALL immediately set data_out=9'h000, data_valid=0, parity_error=0, ready=0, collision_count=0, state=INIT, init pointer=0.
REQ-027 After reset deasserts, the block SHALL re-run the full INIT clear; memory contents prior to reset are not preserved.

Verification (ADDR_W=4)
REQ-028 Reset, release -> ready=0 for 16 cycles, ready=1 on the 16th edge after release; read of every address returns 9'h000, parity_error=0.
REQ-029 Write 8'hA5 @3, then read @3 next cycle -> one cycle later data_out=9'h0A5, data_valid=1 for 1 cycle, parity_error=0; write 8'h07 @15, read -> 9'h107.
REQ-030 Write 8'hA5 @3 with inj_par=1, read @3 -> data_out=9'h1A5, parity_error=1.
REQ-031 Write and read both high for 3 cycles at address 5 after storing 8'h3C there -> collision_count=3, data_valid stays 0, subsequent read @5 returns 9'h03C; preload count to 16'hFFFF via long collision burst -> holds 16'hFFFF.
REQ-032 Assert reset at INIT cycle 7 and during a pending read -> outputs zero immediately, no data_valid, ready rises 16 cycles after release.

Source files
------------

// File: rtl/my_mem_responder.sv
// my_mem_responder: single-port 9-bit parity-protected memory responder.
// After reset it spends DEPTH cycles clearing the array, then it accepts
// one read or one write per cycle. A read returns {parity, data} with
// one cycle of latency, together with a registered parity check.
//
// Ports:
//   clk             in   clock, all state updates on rising edge
//   reset           in   asynchronous active-high reset
//   write           in   write request
//   read            in   read request
//   data_in         in   8-bit write data
//   address         in   ADDR_W-bit word address
//   inj_par         in   invert the stored parity bit of an accepted write (test only)
//   data_out        out  9-bit read data {parity, data}
//   data_valid      out  one-cycle strobe for new read data
//   ready           out  high once the clear sweep has finished
//   collision_count out  saturating count of IDLE cycles with write and read both high
//   parity_error    out  parity mismatch on the returned word, qualified by data_valid
module my_mem_responder #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic              read,
    input  logic [7:0]        data_in,
    input  logic [ADDR_W-1:0] address,
    input  logic              inj_par,
    output logic [8:0]        data_out,
    output logic              data_valid,
    output logic              ready,
    output logic [15:0]       collision_count,
    output logic              parity_error
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned WORD_W = 9;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [WORD_W-1:0]   data_out_q, data_out_d;
    logic                data_valid_q, data_valid_d;
    logic                ready_q, ready_d;
    logic [CNT_W-1:0]    coll_q, coll_d;
    logic                perr_q, perr_d;

    logic [WORD_W-1:0]   mem_q [DEPTH];

    logic                mem_we_c;
    logic [ADDR_W-1:0]   mem_waddr_c;
    logic [WORD_W-1:0]   mem_wdata_c;
    logic [WORD_W-1:0]   rd_word_c;

    // Asynchronous array read; the result is captured into data_out_q.
    always_comb begin
        rd_word_c = mem_q[address];
    end

    // Next-state, memory write port and output register inputs.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        coll_d       = coll_q;
        perr_d       = 1'b0;
        mem_we_c     = 1'b0;
        mem_waddr_c  = address;
        mem_wdata_c  = {(^data_in) ^ inj_par, data_in};

        case (state_q)
            ST_INIT: begin
                // Clear sweep; user requests are ignored until it completes.
                mem_we_c    = 1'b1;
                mem_waddr_c = ptr_q;
                mem_wdata_c = WORD_W'(0);
                ptr_d       = ptr_q + ADDR_W'(1);
                if (ptr_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (write && read) begin
                    // Collision: no access, only the saturating counter moves.
                    if (coll_q != {CNT_W{1'b1}}) begin
                        coll_d = coll_q + CNT_W'(1);
                    end
                end else if (write) begin
                    mem_we_c = 1'b1;
                end else if (read) begin
                    data_out_d   = rd_word_c;
                    data_valid_d = 1'b1;
                    perr_d       = rd_word_c[8] ^ (^rd_word_c[7:0]);
                end
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = ADDR_W'(0);
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            ptr_q        <= ADDR_W'(0);
            data_out_q   <= WORD_W'(0);
            data_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            coll_q       <= CNT_W'(0);
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            ready_q      <= ready_d;
            coll_q       <= coll_d;
            perr_q       <= perr_d;
        end
    end

    // Storage array; contents are rebuilt by the clear sweep after every reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
    end

    assign data_out        = data_out_q;
    assign data_valid      = data_valid_q;
    assign ready           = ready_q;
    assign collision_count = coll_q;
    assign parity_error    = perr_q;

endmodule

// File: tb/tb_my_mem_responder.sv
// Self-checking bench for my_mem_responder with ADDR_W=4 (16 words).
module tb_my_mem_responder;

    localparam int unsigned AW = 4;

    logic          clk;
    logic          reset;
    logic          write;
    logic          read;
    logic [7:0]    data_in;
    logic [AW-1:0] address;
    logic          inj_par;
    logic [8:0]    data_out;
    logic          data_valid;
    logic          ready;
    logic [15:0]   collision_count;
    logic          parity_error;

    int checks;
    int failures;

    my_mem_responder #(.ADDR_W(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .write          (write),
        .read           (read),
        .data_in        (data_in),
        .address        (address),
        .inj_par        (inj_par),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .ready          (ready),
        .collision_count(collision_count),
        .parity_error   (parity_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [7:0]    din;
        logic [AW-1:0] addr;
        logic          inj;
        logic          exp_vld;
        logic [8:0]    exp_out;
        logic          exp_perr;
        logic [15:0]   exp_coll;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wr, logic rd, logic [7:0] din, logic [AW-1:0] addr,
                                logic inj, logic vld, logic [8:0] dout, logic perr,
                                logic [15:0] coll);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din; v.addr = addr; v.inj = inj;
        v.exp_vld = vld; v.exp_out = dout; v.exp_perr = perr; v.exp_coll = coll;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [7:0] din,
                         input logic [AW-1:0] addr, input logic inj);
        write = wr; read = rd; data_in = din; address = addr; inj_par = inj;
    endtask

    // One clock: inputs set now, outputs observed at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_data_out"}, 32'(data_out), 32'h0);
        chk({tag, "_valid"}, 32'(data_valid), 32'h0);
        chk({tag, "_ready"}, 32'(ready), 32'h0);
        chk({tag, "_coll"}, 32'(collision_count), 32'h0);
        chk({tag, "_perr"}, 32'(parity_error), 32'h0);
    endtask

    // Clear sweep: ready low for 15 edges, high on the 16th; user traffic ignored.
    task automatic run_init(input string tag);
        for (int i = 1; i <= 16; i++) begin
            step();
            chk({tag, "_ready"}, 32'(ready), (i == 16) ? 32'h1 : 32'h0);
            chk({tag, "_valid"}, 32'(data_valid), 32'h0);
            chk({tag, "_coll"}, 32'(collision_count), 32'h0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        drive(1'b0, 1'b0, 8'h00, '0, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset0");

        // Writes during INIT must not land in memory.
        drive(1'b1, 1'b0, 8'hFF, 4'd0, 1'b0);
        reset = 1'b0;
        run_init("init0");

        // Every address reads back cleared, one read per cycle.
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 1'b1, 8'h00, AW'(a), 1'b0);
            step();
            chk("sweep_valid", 32'(data_valid), 32'h1);
            chk("sweep_data", 32'(data_out), 32'h0);
            chk("sweep_perr", 32'(parity_error), 32'h0);
        end

        // Directed table: one entry per clock.
        vecs.push_back(mk(1, 0, 8'hA5, 4'd3,  0, 0, 9'h000, 0, 16'd0));
        vecs.push_back(mk(0, 1, 8'h00, 4'd3,  0, 1, 9'h0A5, 0, 16'd0));
        vecs.push_back(mk(0, 0, 8'h00, 4'd3,  0, 0, 9'h0A5, 0, 16'd0));
        vecs.push_back(mk(1, 0, 8'h07, 4'd15, 0, 0, 9'h0A5, 0, 16'd0));
        vecs.push_back(mk(0, 1, 8'h00, 4'd15, 0, 1, 9'h107, 0, 16'd0));
        vecs.push_back(mk(1, 0, 8'hA5, 4'd3,  1, 0, 9'h107, 0, 16'd0));
        vecs.push_back(mk(0, 1, 8'h00, 4'd3,  0, 1, 9'h1A5, 1, 16'd0));
        vecs.push_back(mk(0, 0, 8'h00, 4'd3,  0, 0, 9'h1A5, 0, 16'd0));
        vecs.push_back(mk(1, 0, 8'h3C, 4'd5,  0, 0, 9'h1A5, 0, 16'd0));
        vecs.push_back(mk(1, 1, 8'hFF, 4'd5,  0, 0, 9'h1A5, 0, 16'd1));
        vecs.push_back(mk(1, 1, 8'hFF, 4'd5,  0, 0, 9'h1A5, 0, 16'd2));
        vecs.push_back(mk(1, 1, 8'hFF, 4'd5,  0, 0, 9'h1A5, 0, 16'd3));
        vecs.push_back(mk(0, 1, 8'h00, 4'd5,  0, 1, 9'h03C, 0, 16'd3));
        vecs.push_back(mk(0, 1, 8'h00, 4'd3,  0, 1, 9'h1A5, 1, 16'd3));
        vecs.push_back(mk(0, 1, 8'h00, 4'd15, 0, 1, 9'h107, 0, 16'd3));
        vecs.push_back(mk(1, 0, 8'hFF, 4'd0,  0, 0, 9'h107, 0, 16'd3));
        vecs.push_back(mk(0, 1, 8'h00, 4'd0,  0, 1, 9'h0FF, 0, 16'd3));
        vecs.push_back(mk(1, 0, 8'h01, 4'd9,  0, 0, 9'h0FF, 0, 16'd3));
        vecs.push_back(mk(0, 1, 8'h00, 4'd9,  0, 1, 9'h101, 0, 16'd3));

        foreach (vecs[i]) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].din, vecs[i].addr, vecs[i].inj);
            step();
            chk($sformatf("vec%0d_valid", i), 32'(data_valid), 32'(vecs[i].exp_vld));
            chk($sformatf("vec%0d_data", i), 32'(data_out), 32'(vecs[i].exp_out));
            chk($sformatf("vec%0d_perr", i), 32'(parity_error), 32'(vecs[i].exp_perr));
            chk($sformatf("vec%0d_coll", i), 32'(collision_count), 32'(vecs[i].exp_coll));
        end

        // Reset arriving while a read result is being presented.
        drive(1'b0, 1'b1, 8'h00, 4'd3, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_zero_outputs("rst_read");
        drive(1'b1, 1'b1, 8'h55, 4'd3, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Reset again at INIT cycle 7, with collisions driven throughout.
        for (int i = 1; i <= 7; i++) begin
            step();
            chk("init1_ready", 32'(ready), 32'h0);
            chk("init1_coll", 32'(collision_count), 32'h0);
        end
        reset = 1'b1;
        #1;
        chk_zero_outputs("rst_init7");
        @(negedge clk);
        reset = 1'b0;
        run_init("init2");

        // Previously written word must be gone after the re-run clear.
        drive(1'b0, 1'b1, 8'h00, 4'd3, 1'b0);
        step();
        chk("post_rst_valid", 32'(data_valid), 32'h1);
        chk("post_rst_data", 32'(data_out), 32'h0);

        // Long collision burst to saturation.
        drive(1'b1, 1'b1, 8'h00, 4'd1, 1'b0);
        repeat (65534) @(posedge clk);
        @(negedge clk);
        chk("sat_fffe", 32'(collision_count), 32'hFFFE);
        step();
        chk("sat_ffff", 32'(collision_count), 32'hFFFF);
        repeat (4) step();
        chk("sat_hold", 32'(collision_count), 32'hFFFF);
        chk("sat_valid", 32'(data_valid), 32'h0);

        drive(1'b0, 0, 8'h00, 4'd0, 1'b0);
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
